painterengine_gpu_framefetch: RTL and testbench
===============================================

// Module: painterengine_gpu_framefetch
// PURPOSE
//  Parametrised frame-fetch sequencer for the GPU display path. Walks a clipped image row by row,
//  issuing bounded DMA read bursts into the pixel FIFO once enough FIFO space is free.
//  Extends the single-shot display streamer with: programmable pitch and bytes-per-pixel,
//  burst retry on reader error, continuous per-frame restart, and abort.
//  Single clock domain; sits between the register file, the DMA reader and the display FIFO.
// PARAMETERS
//  ADDR_WIDTH        32   byte-address width
//  DIM_WIDTH         16   width/height/counter width
//  BLOCK_SIZE        64   max pixels per burst (>=1)
//  LAUNCH_THRESHOLD  48   min free FIFO entries required before a burst starts
//  COUNT_WIDTH       8    width of i_wire_fifo_empty_count
//  MAX_RETRY         3    reader errors tolerated per burst before entering ERROR
// PORTS
//  i_wire_clock               in   1           clock
//  i_wire_reset               in   1           asynchronous, active-high reset
//  i_wire_start               in   1           pulse: latch config and fetch one frame
//  i_wire_continuous          in   1           1 = restart on i_wire_frame_sync after DONE
//  i_wire_frame_sync          in   1           frame-start pulse from the display timing
//  i_wire_abort               in   1           pulse: drop the current frame and go IDLE
//  i_wire_image_address       in   ADDR_WIDTH  byte address of pixel (0,0)
//  i_wire_image_pitch         in   ADDR_WIDTH  bytes between row starts
//  i_wire_clip_width          in   DIM_WIDTH   pixels per row to fetch
//  i_wire_clip_height         in   DIM_WIDTH   rows to fetch
//  i_wire_bpp_log2            in   2           log2(bytes per pixel): 0..3 = 1/2/4/8 bytes
//  i_wire_fifo_empty_count    in   COUNT_WIDTH free FIFO entries
//  o_wire_reader_address      out  ADDR_WIDTH  burst byte address
//  o_wire_reader_length       out  32          burst length in pixels
//  o_wire_reader_enable       out  1           level: reader runs while 1
//  i_wire_reader_done         in   1           burst complete
//  i_wire_reader_error        in   1           burst failed
//  o_wire_busy                out  1           1 in LOAD/WAIT_SPACE/STREAM/ADVANCE
//  o_wire_frame_done          out  1           one-cycle pulse when a frame completes
//  o_wire_error               out  1           sticky; cleared by start or reset
//  o_wire_state               out  3           current FSM state code
//  o_wire_line                out  DIM_WIDTH   current row index
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE(0); internal x, y, row_base and retry counters are 0.
//  States: IDLE=0, LOAD=1, WAIT_SPACE=2, STREAM=3, ADVANCE=4, DONE=5, ERROR=6.
//  start is accepted in IDLE, DONE and ERROR; it is ignored while busy.
//   On accept: latch address, pitch, width, height and bpp; row_base=address; x=y=0; error=0.
//   If width==0 or height==0: go to DONE and pulse frame_done on the next cycle; no burst is issued.
//   Otherwise go to LOAD.
//  LOAD (1 cycle): address = row_base + (x << bpp); length = min(BLOCK_SIZE, width - x); go WAIT_SPACE.
//   No multiplier: row_base advances by pitch once per row (ADDR_WIDTH wrap-around is allowed).
//  WAIT_SPACE: enable=0. When empty_count >= LAUNCH_THRESHOLD, go STREAM; enable=1 from the next cycle.
//  STREAM: enable is held at 1; address and length stay stable.
//   done (and no error): x += length; retry = 0; enable=0; go ADVANCE.
//   error (wins over a simultaneous done): enable=0.
//    If retry < MAX_RETRY: retry++ and go WAIT_SPACE with the same address and length.
//    Otherwise set o_wire_error and go ERROR.
//  ADVANCE (1 cycle):
//   If x == width: x=0, y++, row_base += pitch.
//    If y+1 == height: go DONE and pulse frame_done; otherwise go LOAD.
//   Otherwise go LOAD.
//  DONE: enable=0, busy=0.
//   If continuous=1 and frame_sync=1: re-latch config and restart as on start. start also restarts.
//  ERROR: enable=0; held until start, abort or reset.
//  abort in any state: next edge state=IDLE and enable=0; x, y and retry are cleared.
//   abort has priority over start, done and error in the same cycle.
//  frame_sync outside DONE is ignored. Config inputs are sampled only at start/restart.
// TESTING
//  T1: addr=0x1000, pitch=512, width=100, height=2, bpp=2, empty=128, done 3 cycles after enable
//      -> bursts (0x1000,64), (0x1100,36), (0x1200,64), (0x1300,36); exactly one frame_done pulse.
//  T2: width=0, start -> DONE within 2 cycles, one frame_done pulse, enable never asserted.
//  T3: empty_count=40 -> held in WAIT_SPACE with enable=0; raise to 48 -> enable=1 one cycle later.
//  T4: error on burst 0 twice, then done -> (0x1000,64) issued 3 times, o_wire_error stays 0.
//      Error 4 times -> ERROR state, o_wire_error=1; a new start clears it and refetches from 0x1000.
//  T5: continuous=1, frame_sync in DONE -> new frame starting at the latched address.
//      frame_sync during STREAM has no effect.
//  T6: reset asserted mid-STREAM -> enable=0 immediately (asynchronous). abort mid-STREAM with
//      simultaneous done -> IDLE next edge, no ADVANCE, no frame_done.

Source files
------------

// File: rtl/painterengine_gpu_framefetch.sv
// Frame-fetch sequencer: walks a clipped image row by row and issues bounded DMA read
// bursts into the display FIFO, with retry on reader error, per-frame restart and abort.
module painterengine_gpu_framefetch #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DIM_WIDTH        = 16,
    parameter int BLOCK_SIZE       = 64,
    parameter int LAUNCH_THRESHOLD = 48,
    parameter int COUNT_WIDTH      = 8,
    parameter int MAX_RETRY        = 3
) (
    input  logic                   i_wire_clock,
    input  logic                   i_wire_reset,
    input  logic                   i_wire_start,
    input  logic                   i_wire_continuous,
    input  logic                   i_wire_frame_sync,
    input  logic                   i_wire_abort,
    input  logic [ADDR_WIDTH-1:0]  i_wire_image_address,
    input  logic [ADDR_WIDTH-1:0]  i_wire_image_pitch,
    input  logic [DIM_WIDTH-1:0]   i_wire_clip_width,
    input  logic [DIM_WIDTH-1:0]   i_wire_clip_height,
    input  logic [1:0]             i_wire_bpp_log2,
    input  logic [COUNT_WIDTH-1:0] i_wire_fifo_empty_count,
    output logic [ADDR_WIDTH-1:0]  o_wire_reader_address,
    output logic [31:0]            o_wire_reader_length,
    output logic                   o_wire_reader_enable,
    input  logic                   i_wire_reader_done,
    input  logic                   i_wire_reader_error,
    output logic                   o_wire_busy,
    output logic                   o_wire_frame_done,
    output logic                   o_wire_error,
    output logic [2:0]             o_wire_state,
    output logic [DIM_WIDTH-1:0]   o_wire_line
);
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_WAIT_SPACE = 3'd2,
        ST_STREAM     = 3'd3,
        ST_ADVANCE    = 3'd4,
        ST_DONE       = 3'd5,
        ST_ERROR      = 3'd6
    } state_t;

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [DIM_WIDTH-1:0]   D_ONE   = DIM_WIDTH'(1);
    localparam logic [DIM_WIDTH-1:0]   D_BLOCK = DIM_WIDTH'(BLOCK_SIZE);
    localparam logic [COUNT_WIDTH-1:0] C_THR   = COUNT_WIDTH'(LAUNCH_THRESHOLD);
    localparam logic [RW-1:0]          R_MAX   = RW'(MAX_RETRY);
    localparam logic [RW-1:0]          R_ONE   = RW'(1);

    state_t                  r_state, w_state_nxt;
    logic                    w_accept, w_zero_dim, w_space_ok, w_row_end, w_last_row;
    logic [ADDR_WIDTH-1:0]   r_pitch, r_row_base, r_address, w_addr;
    logic [DIM_WIDTH-1:0]    r_width, r_height, r_x, r_y, w_remain, w_chunk, w_y_inc;
    logic [1:0]              r_bpp;
    logic [RW-1:0]           r_retry;
    logic [31:0]             r_length;
    logic                    r_enable, r_frame_done, r_error;

    assign w_zero_dim = (i_wire_clip_width == '0) || (i_wire_clip_height == '0);
    assign w_space_ok = (i_wire_fifo_empty_count >= C_THR);
    assign w_remain   = r_width - r_x;
    assign w_chunk    = (w_remain > D_BLOCK) ? D_BLOCK : w_remain;
    assign w_addr     = r_row_base + (ADDR_WIDTH'(r_x) << r_bpp);
    assign w_y_inc    = r_y + D_ONE;
    assign w_row_end  = (r_x == r_width);
    assign w_last_row = (w_y_inc == r_height);

    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) r_state <= ST_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        if (i_wire_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_ERROR: w_accept = i_wire_start;
                ST_DONE:           w_accept = i_wire_start | (i_wire_continuous & i_wire_frame_sync);
                ST_LOAD:           w_state_nxt = ST_WAIT_SPACE;
                ST_WAIT_SPACE:     if (w_space_ok) w_state_nxt = ST_STREAM;
                ST_STREAM: begin
                    // error wins over a same-cycle done
                    if (i_wire_reader_error)
                        w_state_nxt = (r_retry < R_MAX) ? ST_WAIT_SPACE : ST_ERROR;
                    else if (i_wire_reader_done)
                        w_state_nxt = ST_ADVANCE;
                end
                ST_ADVANCE:        w_state_nxt = (w_row_end && w_last_row) ? ST_DONE : ST_LOAD;
                default:           w_state_nxt = ST_IDLE;
            endcase
            if (w_accept) w_state_nxt = w_zero_dim ? ST_DONE : ST_LOAD;
        end
    end

    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            r_pitch      <= '0;
            r_row_base   <= '0;
            r_address    <= '0;
            r_length     <= '0;
            r_width      <= '0;
            r_height     <= '0;
            r_bpp        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_retry      <= '0;
            r_enable     <= 1'b0;
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_enable     <= (w_state_nxt == ST_STREAM);
            // pulse on entry to DONE, including a zero-size restart from DONE itself
            r_frame_done <= (w_state_nxt == ST_DONE) && ((r_state != ST_DONE) || w_accept);
            if (i_wire_abort) begin
                r_x     <= '0;
                r_y     <= '0;
                r_retry <= '0;
            end else if (w_accept) begin
                r_pitch    <= i_wire_image_pitch;
                r_width    <= i_wire_clip_width;
                r_height   <= i_wire_clip_height;
                r_bpp      <= i_wire_bpp_log2;
                r_row_base <= i_wire_image_address;
                r_x        <= '0;
                r_y        <= '0;
                r_retry    <= '0;
                r_error    <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        r_address <= w_addr;
                        r_length  <= 32'(w_chunk);
                    end
                    ST_STREAM: begin
                        if (i_wire_reader_error) begin
                            if (r_retry < R_MAX) r_retry <= r_retry + R_ONE;
                            else                 r_error <= 1'b1;
                        end else if (i_wire_reader_done) begin
                            r_x     <= r_x + r_length[DIM_WIDTH-1:0];
                            r_retry <= '0;
                        end
                    end
                    ST_ADVANCE: begin
                        // row_base accumulates pitch so no multiplier is needed
                        if (w_row_end) begin
                            r_x        <= '0;
                            r_y        <= w_y_inc;
                            r_row_base <= r_row_base + r_pitch;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_wire_reader_address = r_address;
    assign o_wire_reader_length  = r_length;
    assign o_wire_reader_enable  = r_enable;
    assign o_wire_busy           = (r_state == ST_LOAD) || (r_state == ST_WAIT_SPACE) ||
                                   (r_state == ST_STREAM) || (r_state == ST_ADVANCE);
    assign o_wire_frame_done     = r_frame_done;
    assign o_wire_error          = r_error;
    assign o_wire_state          = r_state;
    assign o_wire_line           = r_y;
endmodule

// File: tb/tb_painterengine_gpu_framefetch.sv
// Bench for the frame-fetch sequencer: table vectors, random frames against a burst-list
// model, and hand-written sequences for wait/retry/restart/reset/abort corners.
module tb_painterengine_gpu_framefetch;
    localparam int BS = 64;

    logic        clk;
    logic        rst, start, cont, fsync, abort_i;
    logic [31:0] addr_i, pitch_i;
    logic [15:0] w_i, h_i;
    logic [1:0]  bpp_i;
    logic [7:0]  empty;
    logic [31:0] rd_addr, rd_len;
    logic        en, busy, fdone, err;
    logic [2:0]  st;
    logic [15:0] line;
    logic        rsp_done, rsp_err, man_done, man_err;
    wire         rd_done = rsp_done | man_done;
    wire         rd_err  = rsp_err | man_err;

    painterengine_gpu_framefetch dut (
        .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_start(start),
        .i_wire_continuous(cont), .i_wire_frame_sync(fsync), .i_wire_abort(abort_i),
        .i_wire_image_address(addr_i), .i_wire_image_pitch(pitch_i),
        .i_wire_clip_width(w_i), .i_wire_clip_height(h_i), .i_wire_bpp_log2(bpp_i),
        .i_wire_fifo_empty_count(empty), .o_wire_reader_address(rd_addr),
        .o_wire_reader_length(rd_len), .o_wire_reader_enable(en),
        .i_wire_reader_done(rd_done), .i_wire_reader_error(rd_err), .o_wire_busy(busy),
        .o_wire_frame_done(fdone), .o_wire_error(err), .o_wire_state(st), .o_wire_line(line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] a; logic [31:0] l; } burst_t;
    typedef struct {
        logic [31:0] a, p;
        int w, h, b, exp_n;
        logic [31:0] exp_la, exp_ll;
        int exp_line;
    } vec_t;

    burst_t mon_q[$];
    burst_t exp_q[$];
    int plan_all[$];
    int err_plan[$];
    int cur_errs, fd_cnt, en_cnt, rsp_dmax, checks, failures;
    bit rsp_on;

    // reader model: answers each enable after a random delay, erroring as the plan says
    initial begin
        int cnt, d;
        rsp_done = 0; rsp_err = 0; cnt = 0; d = 1;
        forever begin
            @(negedge clk);
            rsp_done = 0; rsp_err = 0;
            if (rsp_on && en) begin
                if (cnt == 0) d = $urandom_range(1, rsp_dmax);
                cnt++;
                if (cnt >= d) begin
                    cnt = 0;
                    if (cur_errs > 0) begin rsp_err = 1; cur_errs--; end
                    else begin
                        rsp_done = 1;
                        cur_errs = (err_plan.size() > 0) ? err_plan.pop_front() : 0;
                    end
                end
            end else cnt = 0;
        end
    end

    // monitor: one record per enable rising edge
    initial begin
        logic pe;
        pe = 0;
        forever begin
            @(negedge clk);
            if (en && !pe) mon_q.push_back({rd_addr, rd_len});
            if (fdone) fd_cnt++;
            if (en) en_cnt++;
            pe = en;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    // expected burst list straight from the frame geometry; each burst repeats once per error
    function automatic void build_exp(input logic [31:0] a, p, input int w, h, b);
        int k;
        k = 0;
        exp_q.delete();
        for (int row = 0; row < h; row++)
            for (int x = 0; x < w; x += BS) begin
                burst_t e;
                int reps;
                e.a = a + p * 32'(row) + (32'(x) << b);
                e.l = 32'((w - x < BS) ? (w - x) : BS);
                reps = (k < plan_all.size()) ? plan_all[k] : 0;
                for (int r = 0; r <= reps; r++) exp_q.push_back(e);
                k++;
            end
    endfunction

    task automatic do_start(input logic [31:0] a, p, input int w, h, b);
        addr_i = a; pitch_i = p; w_i = 16'(w); h_i = 16'(h); bpp_i = 2'(b);
        start = 1; step(); start = 0;
    endtask

    task automatic wait_fd(input int maxc);
        int n;
        n = 0;
        while (fd_cnt == 0 && n < maxc) begin step(); n++; end
    endtask

    task automatic wait_en(input string nm);
        int n;
        n = 0;
        while (!en && n < 200) begin step(); n++; end
        chk({nm, " enable seen"}, en, 1);
    endtask

    task automatic prep(input int emax, input int first);
        plan_all.delete();
        for (int i = 0; i < 64; i++) plan_all.push_back((emax == 0) ? 0 : int'($urandom_range(0, emax)));
        if (first >= 0) plan_all[0] = first;
        err_plan = plan_all;
        cur_errs = err_plan.pop_front();
        mon_q.delete(); fd_cnt = 0; en_cnt = 0;
    endtask

    task automatic compare_bursts(input string nm);
        chk({nm, " burst count"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s burst%0d addr", nm, i), mon_q[i].a, exp_q[i].a);
            chk($sformatf("%s burst%0d len", nm, i), mon_q[i].l, exp_q[i].l);
        end
    endtask

    task automatic run_frame(input logic [31:0] a, p, input int w, h, b, emax, first, input string nm);
        prep(emax, first);
        build_exp(a, p, w, h, b);
        rsp_on = 1;
        do_start(a, p, w, h, b);
        if (w == 0 || h == 0) chk({nm, " state after start"}, st, 5);
        wait_fd(5000);
        repeat (3) step();
        chk({nm, " frame_done count"}, fd_cnt, 1);
        compare_bursts(nm);
        chk({nm, " error flag"}, err, 0);
        chk({nm, " state done"}, st, 5);
        chk({nm, " busy"}, busy, 0);
    endtask

    vec_t vt[7];

    initial begin
        checks = 0; failures = 0; rsp_on = 0; rsp_dmax = 3; cur_errs = 0;
        fd_cnt = 0; en_cnt = 0;
        rst = 1; start = 0; cont = 0; fsync = 0; abort_i = 0; man_done = 0; man_err = 0;
        addr_i = 0; pitch_i = 0; w_i = 0; h_i = 0; bpp_i = 0; empty = 8'd128;

        vt[0] = '{32'h1000, 32'd512, 100, 2, 2, 4, 32'h1300, 32'd36, 2};
        vt[1] = '{32'h0, 32'd16, 1, 1, 0, 1, 32'h0, 32'd1, 1};
        vt[2] = '{32'h2000, 32'h100, 64, 3, 0, 3, 32'h2200, 32'd64, 3};
        vt[3] = '{32'h2000, 32'h100, 65, 1, 3, 2, 32'h2200, 32'd1, 1};
        vt[4] = '{32'hFFFF_FF00, 32'h100, 10, 2, 1, 2, 32'h0, 32'd10, 2};
        vt[5] = '{32'h3000, 32'd64, 0, 5, 1, 0, 32'h0, 32'h0, 0};
        vt[6] = '{32'h3000, 32'd64, 10, 0, 1, 0, 32'h0, 32'h0, 0};

        repeat (2) step();
        chk("reset state", st, 0);
        chk("reset enable", en, 0);
        chk("reset busy", busy, 0);
        chk("reset frame_done", fdone, 0);
        chk("reset error", err, 0);
        chk("reset line", line, 0);
        chk("reset address", rd_addr, 0);
        chk("reset length", rd_len, 0);
        rst = 0; step();

        for (int i = 0; i < 7; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            run_frame(vt[i].a, vt[i].p, vt[i].w, vt[i].h, vt[i].b, 0, 0, nm);
            chk({nm, " n"}, mon_q.size(), vt[i].exp_n);
            if (vt[i].exp_n > 0 && mon_q.size() > 0) begin
                chk({nm, " last addr"}, mon_q[mon_q.size()-1].a, vt[i].exp_la);
                chk({nm, " last len"}, mon_q[mon_q.size()-1].l, vt[i].exp_ll);
            end
            if (vt[i].exp_n == 0) chk({nm, " no enable"}, en_cnt, 0);
            chk({nm, " line"}, line, vt[i].exp_line);
        end

        for (int i = 0; i < 10; i++) begin
            rsp_dmax = $urandom_range(1, 4);
            run_frame($urandom, $urandom, $urandom_range(1, 200), $urandom_range(1, 3),
                      $urandom_range(0, 3), 3, -1, $sformatf("rand%0d", i));
        end
        rsp_dmax = 3;

        // held in WAIT_SPACE until the FIFO has room
        prep(0, 0); rsp_on = 1; empty = 8'd40;
        do_start(32'h5000, 32'd64, 8, 1, 0);
        repeat (5) step();
        chk("T3 wait state", st, 2);
        chk("T3 wait enable", en, 0);
        chk("T3 wait busy", busy, 1);
        empty = 8'd48; step();
        chk("T3 enable after space", en, 1);
        chk("T3 stream state", st, 3);
        empty = 8'd128;
        wait_fd(500); repeat (2) step();
        chk("T3 frame_done", fd_cnt, 1);

        // two errors are retried, four end in ERROR
        run_frame(32'h1000, 32'd512, 64, 1, 0, 0, 2, "T4 retry");
        chk("T4 retry issues", mon_q.size(), 3);
        prep(0, 4);
        do_start(32'h1000, 32'd512, 64, 1, 0);
        begin
            int n;
            n = 0;
            while (st != 3'd6 && n < 300) begin step(); n++; end
        end
        chk("T4 error state", st, 6);
        chk("T4 error flag", err, 1);
        chk("T4 error attempts", mon_q.size(), 4);
        chk("T4 error no frame_done", fd_cnt, 0);
        chk("T4 error enable", en, 0);
        run_frame(32'h1000, 32'd512, 100, 2, 2, 0, 0, "T4 restart");

        // continuous restart on frame_sync; sync during STREAM ignored
        cont = 1;
        run_frame(32'h4000, 32'h80, 10, 2, 1, 0, 0, "T5 first");
        prep(0, 0);
        build_exp(32'h4000, 32'h80, 10, 2, 1);
        fsync = 1; step(); fsync = 0;
        wait_en("T5 restart");
        fsync = 1; step(); fsync = 0;
        wait_fd(500); repeat (3) step();
        chk("T5 frame_done", fd_cnt, 1);
        compare_bursts("T5 restart");
        if (mon_q.size() == 2) begin
            chk("T5 first addr", mon_q[0].a, 32'h4000);
            chk("T5 second addr", mon_q[1].a, 32'h4080);
        end
        repeat (5) step();
        chk("T5 stays done", st, 5);
        cont = 0; en_cnt = 0;
        fsync = 1; step(); fsync = 0;
        repeat (3) step();
        chk("T5 sync ignored state", st, 5);
        chk("T5 sync ignored enable", en_cnt, 0);

        // asynchronous reset mid-burst
        prep(0, 0); rsp_on = 0;
        do_start(32'h1000, 32'd512, 64, 1, 0);
        wait_en("T6 reset");
        rst = 1; #1;
        chk("T6 reset enable", en, 0);
        chk("T6 reset state", st, 0);
        step(); rst = 0; step();

        // abort with a simultaneous done, in the second row
        prep(0, 0); rsp_on = 0;
        do_start(32'h1000, 32'd512, 64, 2, 0);
        wait_en("T6 row0");
        man_done = 1; step(); man_done = 0;
        wait_en("T6 row1");
        chk("T6 line before abort", line, 1);
        abort_i = 1; man_done = 1; step(); abort_i = 0; man_done = 0;
        chk("T6 abort state", st, 0);
        chk("T6 abort enable", en, 0);
        chk("T6 abort line", line, 0);
        repeat (4) step();
        chk("T6 abort no frame_done", fd_cnt, 0);
        chk("T6 abort idle", st, 0);
        run_frame(32'h1000, 32'd512, 64, 2, 0, 0, 0, "T6 after abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
